// File: rtl/ov7670_config_seq_if.sv
// Write-request channel between the config sequencer and the SCCB master:
// valid/ready request carrying {reg, data}, then a done pulse with NACK flag.
interface ov7670_config_seq_if #(
  parameter int REG_W  = 8,
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              wr_err;

  modport master (
    output wr_valid, wr_reg, wr_data,
    input  wr_ready, wr_done, wr_err
  );

  modport slave (
    input  wr_valid, wr_reg, wr_data,
    output wr_ready, wr_done, wr_err
  );
endinterface

// File: rtl/ov7670_config_seq.sv
// Camera register-init sequencer: walks a synchronous {reg, data} ROM from
// address 0 and issues each entry as an SCCB write, with delay/end entries.
module ov7670_config_seq #(
  parameter int ADDR_W     = 8,
  parameter int REG_W      = 8,
  parameter int DATA_W     = 8,
  parameter int DELAY_UNIT = 1000,
  parameter int RETRIES    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [REG_W+DATA_W-1:0] rom_data,
  ov7670_config_seq_if.master     wr,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int CNT_W = $clog2((2**DATA_W) * DELAY_UNIT);
  localparam int ATT_W = (RETRIES > 1) ? $clog2(RETRIES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_UNIT = CNT_W'(DELAY_UNIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT_DONE,
    S_DELAY,
    S_ADVANCE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [REG_W-1:0]  ent_reg;
  logic [DATA_W-1:0] ent_data;
  logic              ent_end;
  logic              ent_delay;

  assign ent_reg   = rom_data[REG_W+DATA_W-1:DATA_W];
  assign ent_data  = rom_data[DATA_W-1:0];
  assign ent_end   = &rom_data;
  assign ent_delay = &ent_reg;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    att_d   = att_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          att_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (ent_end) begin
          state_d = S_DONE;
        end else if (ent_delay) begin
          // Load N-1 so DELAY lasts exactly (D+1)*DELAY_UNIT cycles.
          state_d = S_DELAY;
          cnt_d   = (CNT_W'(ent_data) + CNT_ONE) * CNT_UNIT - CNT_ONE;
        end else begin
          state_d = S_SEND;
          reg_d   = ent_reg;
          data_d  = ent_data;
        end
      end
      S_SEND: begin
        if (wr.wr_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (wr.wr_done) begin
          if (!wr.wr_err) begin
            state_d = S_ADVANCE;
          end else if (int'(att_q) + 1 < RETRIES) begin
            state_d = S_SEND;
            att_d   = att_q + 1'b1;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) state_d = S_ADVANCE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_ADVANCE: begin
        if (&addr_q) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_FETCH;
          addr_d  = addr_q + 1'b1;
          att_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      att_q   <= '0;
      cnt_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      att_q   <= att_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_addr    = addr_q;
  assign wr.wr_valid = valid_q;
  assign wr.wr_reg   = reg_q;
  assign wr.wr_data  = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Scoreboard bench for ov7670_config_seq: directed ROM tables, a modelled
// SCCB master with stall/NACK knobs, and a monitor that checks every accepted write.
module tb_ov7670_config_seq;
  localparam int ADDR_W   = 8;
  localparam int REG_W    = 8;
  localparam int DATA_W   = 8;
  localparam int DU       = 4;
  localparam int RETRIES  = 3;
  localparam int DONE_LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              busy, done, err;

  ov7670_config_seq_if #(.REG_W(REG_W), .DATA_W(DATA_W)) bus ();

  ov7670_config_seq #(
    .ADDR_W(ADDR_W), .REG_W(REG_W), .DATA_W(DATA_W),
    .DELAY_UNIT(DU), .RETRIES(RETRIES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .wr(bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) rom_data <= mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q [$];

  int stall = 0, nack_left = 0, dcnt = 0;
  bit acc_pend = 0;

  int acc_cnt = 0, start_cyc = 0;
  int first_valid_cyc = -1, last_wd_cyc = -1, done_rise_cyc = -1;
  bit prev_done = 0, prev_hold = 0;
  logic [15:0] prev_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SCCB master model: accepts when valid (after `stall` cycles), pulses done
  // DONE_LAT cycles later, flagging NACK while nack_left > 0.
  initial begin
    bus.wr_ready = 1'b0;
    bus.wr_done  = 1'b0;
    bus.wr_err   = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.wr_done = 1'b0;
      bus.wr_err  = 1'b0;
      if (!rst_n) begin
        acc_pend = 0; dcnt = 0; bus.wr_ready = 1'b0;
      end else begin
        if (acc_pend) dcnt = DONE_LAT;
        else if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            bus.wr_done = 1'b1;
            if (nack_left > 0) begin bus.wr_err = 1'b1; nack_left--; end
          end
        end
        if (bus.wr_valid && dcnt == 0 && stall > 0) begin
          stall--;
          bus.wr_ready = 1'b0;
        end else begin
          bus.wr_ready = bus.wr_valid && dcnt == 0;
        end
        acc_pend = bus.wr_valid && bus.wr_ready;
      end
    end
  end

  // Monitor: scoreboard pop on acceptance, request stability while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_hold) begin
          check("hold_valid", 32'(bus.wr_valid), 32'd1);
          check("hold_word", 32'({bus.wr_reg, bus.wr_data}), 32'(prev_word));
        end
        if (bus.wr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.wr_valid && bus.wr_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got %0h, expected no write", {bus.wr_reg, bus.wr_data});
          end else begin
            check("write", 32'({bus.wr_reg, bus.wr_data}), 32'(exp_q.pop_front()));
          end
        end
        prev_hold = bus.wr_valid && !bus.wr_ready;
        prev_word = {bus.wr_reg, bus.wr_data};
        if (bus.wr_done) last_wd_cyc = cyc;
        if (done && !prev_done) done_rise_cyc = cyc;
        prev_done = done;
      end else begin
        prev_hold = 0;
        prev_done = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #2; end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    step(1);
    first_valid_cyc = -1; last_wd_cyc = -1; done_rise_cyc = -1; acc_cnt = 0;
    start_cyc = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i = 0;
    while (!done && i < limit) begin step(1); i++; end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_wr_valid"}, 32'(bus.wr_valid), 32'd0);
    check({tag, "_wr_reg"}, 32'(bus.wr_reg), 32'd0);
    check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    clear_rom();
    step(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step(2);

    // Basic table
    clear_rom();
    mem[0] = 16'h1280; mem[1] = 16'h1204;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
    pulse_start();
    wait_done(200);
    check("basic_first_valid", 32'(first_valid_cyc - start_cyc), 32'd3);
    check("basic_err", 32'(err), 32'd0);
    check("basic_writes", 32'(acc_cnt), 32'd2);
    check("basic_done_lat", 32'(done_rise_cyc - last_wd_cyc), 32'd4);
    check("basic_queue", 32'(exp_q.size()), 32'd0);

    // Delay entries, plus a start pulse while busy that must be ignored
    clear_rom();
    mem[0] = 16'hFF00; mem[1] = 16'h1100; mem[2] = 16'hFF02;
    exp_q.push_back(16'h1100);
    pulse_start();
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(300);
    check("delay_first_valid", 32'(first_valid_cyc - start_cyc), 32'd10);
    check("delay_done_lat", 32'(done_rise_cyc - last_wd_cyc), 32'd19);
    check("delay_writes", 32'(acc_cnt), 32'd1);
    check("delay_err", 32'(err), 32'd0);

    // Backpressure
    clear_rom();
    mem[0] = 16'h1234; mem[1] = 16'h5678;
    exp_q.push_back(16'h1234); exp_q.push_back(16'h5678);
    stall = 5;
    pulse_start();
    wait_done(300);
    check("bp_writes", 32'(acc_cnt), 32'd2);
    check("bp_err", 32'(err), 32'd0);
    check("bp_first_valid", 32'(first_valid_cyc - start_cyc), 32'd3);

    // Two NACKs, then success
    clear_rom();
    mem[0] = 16'h1A2B; mem[1] = 16'h3C4D;
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h1A2B);
    exp_q.push_back(16'h3C4D);
    nack_left = 2;
    pulse_start();
    wait_done(300);
    check("nack2_writes", 32'(acc_cnt), 32'd4);
    check("nack2_err", 32'(err), 32'd0);

    // NACK on every attempt
    clear_rom();
    mem[0] = 16'h5566; mem[1] = 16'h7788;
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h5566);
    nack_left = 100;
    pulse_start();
    wait_done(300);
    check("nackall_err", 32'(err), 32'd1);
    step(20);
    check("nackall_writes", 32'(acc_cnt), 32'd3);
    check("nackall_done", 32'(done), 32'd1);
    nack_left = 0;

    // Restart from DONE clears err
    clear_rom();
    mem[0] = 16'h1280; mem[1] = 16'h1204;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
    pulse_start();
    check("restart_err_cleared", 32'(err), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    wait_done(200);
    check("restart_first_valid", 32'(first_valid_cyc - start_cyc), 32'd3);
    check("restart_err", 32'(err), 32'd0);

    // Missing end marker: every address is a write
    for (int i = 0; i < 256; i++) begin
      mem[i] = {8'(i >> 1), 8'(i)};
      exp_q.push_back({8'(i >> 1), 8'(i)});
    end
    pulse_start();
    wait_done(4000);
    check("noend_err", 32'(err), 32'd1);
    check("noend_writes", 32'(acc_cnt), 32'd256);
    check("noend_rom_addr", 32'(rom_addr), 32'hFF);
    step(10);
    check("noend_no_wrap", 32'(rom_addr), 32'hFF);

    // Asynchronous reset in the middle of a delay
    clear_rom();
    mem[0] = 16'h1234; mem[1] = 16'hFF10;
    exp_q.push_back(16'h1234);
    pulse_start();
    step(30);
    check("rstmid_busy", 32'(busy), 32'd1);
    check("rstmid_rom_addr", 32'(rom_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    step(2);
    rst_n = 1'b1;
    step(5);
    check("rstmid_idle_busy", 32'(busy), 32'd0);
    check("rstmid_writes", 32'(acc_cnt), 32'd1);
    check("rstmid_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ov7670_config_seq.md
# ov7670_config_seq

Parametrised camera register-init sequencer. Walks an external synchronous config ROM of `{reg, data}` entries from address 0. Issues each entry as a write transaction to the SCCB master over a valid/ready + done handshake. Supports variable-length delay entries, NACK retry, end-of-table detection and restart on demand. Sits between the config ROM and the SCCB master in the camera capture path.

## Interface
- `ADDR_W`, 8: ROM address width; table holds at most 2^ADDR_W entries.
- `REG_W`, 8: register-address field width; entry bits [REG_W+DATA_W-1:DATA_W].
- `DATA_W`, 8: register-data field width; entry bits [DATA_W-1:0].
- `DELAY_UNIT`, 1000: clk cycles per delay unit.
- `RETRIES`, 3: maximum write attempts per entry (≥1).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; starts or restarts the sequence from address 0.
- `rom_addr`  out  ADDR_W  ROM address, registered.
- `rom_data`  in  REG_W+DATA_W  ROM entry; valid one cycle after `rom_addr`.
- `wr_valid`  out  1  write request to SCCB master.
- `wr_ready`  in  1  master accepts the request when `wr_valid & wr_ready`.
- `wr_reg`  out  REG_W  register address of the request.
- `wr_data`  out  DATA_W  register data of the request.
- `wr_done`  in  1  one-cycle pulse: accepted transaction finished.
- `wr_err`  in  1  NACK flag; sampled with `wr_done`.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `err`  out  1  sticky error flag; cleared by `start`.

## Operation
- Entry decode, with R = reg field and D = data field:
  - Entry all ones: end of table.
  - R all ones, D not all ones: delay of (D+1)*DELAY_UNIT cycles.
  - Any other entry: register write.
  - Entry 0xFFF0 at 8/8 widths therefore waits 241 units.
- States:
  - IDLE
    - `start` → FETCH, `rom_addr`=0, attempt counter=0, `err`=0.
  - FETCH
    - `rom_addr` is stable this cycle → DECODE.
  - DECODE
    - End entry → DONE.
    - Delay entry → DELAY; counter loaded with (D+1)*DELAY_UNIT−1.
    - Write entry → SEND; `wr_reg`/`wr_data` latched from the entry.
  - SEND
    - `wr_valid`=1.
    - On `wr_ready` → WAIT_DONE; `wr_valid` drops next cycle.
  - WAIT_DONE
    - `wr_done & !wr_err` → ADVANCE.
    - `wr_done & wr_err` with attempts+1 < RETRIES → SEND; attempts++; same `wr_reg`/`wr_data`.
    - `wr_done & wr_err` otherwise → DONE with `err`=1.
  - DELAY
    - Counts down; at 0 → ADVANCE.
  - ADVANCE
    - `rom_addr` == 2^ADDR_W−1 → DONE with `err`=1 (missing end marker; no wrap).
    - Otherwise `rom_addr`+1, attempts=0 → FETCH.
  - DONE
    - `start` → same action as from IDLE.
- `start` is ignored when `busy`=1.
- `wr_done` outside WAIT_DONE is ignored.
- `wr_reg`/`wr_data` hold stable whenever `wr_valid`=1.
- The delay counter is $clog2(2^DATA_W*DELAY_UNIT) bits wide and never overflows.

## Timing
- Reset values:
  - state IDLE
  - `rom_addr`=0, `wr_valid`=0, `wr_reg`=0, `wr_data`=0
  - `busy`=0, `done`=0, `err`=0
  - counters 0
- Reset mid-operation: `wr_valid` drops asynchronously; no resume.
- Latency for `start` sampled at edge k:
  - FETCH at k+1, DECODE at k+2.
  - `wr_valid` high from k+3 for a write entry.
- Delay entry: exactly (D+1)*DELAY_UNIT cycles in DELAY.
- Per-entry overhead: FETCH, DECODE and ADVANCE = 3 cycles, plus handshake time (write) or delay time (delay).
- A write ends when `wr_done` is sampled high in WAIT_DONE.
  - Next `rom_addr` appears 2 cycles later (ADVANCE, then FETCH).
- `wr_ready` and `wr_done` in the same cycle as acceptance: the `wr_done` is ignored; the master must pulse `wr_done` at least one cycle after acceptance.
- `done` rises the cycle after the DECODE of the end entry.

## Test plan
- **Basic table:** ROM {0x1280, 0x1204, 0xFFFF}, `wr_ready`=1, `wr_done` 3 cycles after accept → two writes (0x12,0x80) then (0x12,0x04); `done`=1, `err`=0; `wr_valid` first high 3 cycles after `start`.
- **Delay:** DELAY_UNIT=4, ROM {0xFF00, 0x1100, 0xFF02, 0xFFFF} → 4 DELAY cycles, then write (0x11,0x00), then 12 DELAY cycles, then `done`.
- **Backpressure:** `wr_ready` low 5 cycles during SEND → `wr_valid`, `wr_reg`, `wr_data` stable; exactly one acceptance; table completes correctly.
- **NACK retry:** RETRIES=3.
  - `wr_err` on the first 2 attempts → 3 accepted requests with identical reg/data, then advance.
  - `wr_err` on all attempts → `done`=1, `err`=1, no further writes.
- **Missing end marker:** ADDR_W=2, four write entries → 4 writes, then `done`=1, `err`=1; `rom_addr` never wraps to 0.
- **Control:**
  - `start` pulsed while busy → ignored.
  - `rst_n` low mid-DELAY → all outputs return to reset values immediately.
  - `start` from DONE → sequence reruns from address 0 with `err` cleared.
